// File: rtl/mux_rr_buffered.sv
// N-channel buffered mux: each channel fills its own FIFO, and a round-robin arbiter
// drains the FIFOs onto one registered valid/ready output stream.

module mux_rr_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

module mux_rr_buffered #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]            valid_in,
  input  logic                         out_ready,
  output logic [NUM_CH-1:0]            full,
  output logic [NUM_CH-1:0]            overflow,
  output logic                         valid_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [$clog2(NUM_CH)-1:0]    ch_out
);

  localparam int CHW = $clog2(NUM_CH);

  logic [DATA_WIDTH-1:0] head [NUM_CH];
  logic [NUM_CH-1:0]     empty;
  logic [NUM_CH-1:0]     push;
  logic [NUM_CH-1:0]     pop;
  logic [CHW-1:0]        last_grant;
  logic [CHW-1:0]        grant_idx;
  logic [CHW-1:0]        cand;
  logic                  grant_found;
  logic                  advance;

  // Full is the registered state, so a same-cycle pop never frees room for a push.
  assign push    = valid_in & ~full;
  assign advance = ~valid_out | out_ready;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    mux_rr_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_fifo (
      .clk    (clk),
      .reset_L(reset_L),
      .push   (push[gi]),
      .pop    (pop[gi]),
      .wdata  (data_in[gi*DATA_WIDTH +: DATA_WIDTH]),
      .head   (head[gi]),
      .full   (full[gi]),
      .empty  (empty[gi])
    );
  end

  // Scan starts just after the last winner so each non-empty channel gets its turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CHW'((int'(last_grant) + k) % NUM_CH);
      if (!grant_found && !empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (advance && grant_found) pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      overflow <= '0;
    end else begin
      overflow <= overflow | (valid_in & full);
    end
  end

  // Output register holds its word and the arbiter pointer while stalled.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      valid_out  <= 1'b0;
      data_out   <= '0;
      ch_out     <= '0;
      last_grant <= CHW'(NUM_CH - 1);
    end else if (advance) begin
      if (grant_found) begin
        valid_out  <= 1'b1;
        data_out   <= head[grant_idx];
        ch_out     <= grant_idx;
        last_grant <= grant_idx;
      end else begin
        valid_out <= 1'b0;
        data_out  <= '0;
        ch_out    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_buffered.sv
// Scoreboard bench for mux_rr_buffered: a queue-based model predicts delivered words and flags,
// a negedge monitor compares them against the DUT.

module tb_mux_rr_buffered;

  localparam int DW    = 8;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int CHW   = 2;

  logic              clk = 1'b0;
  logic              reset_L;
  logic [NCH*DW-1:0] data_in;
  logic [NCH-1:0]    valid_in;
  logic              out_ready;
  logic [NCH-1:0]    full;
  logic [NCH-1:0]    overflow;
  logic              valid_out;
  logic [DW-1:0]     data_out;
  logic [CHW-1:0]    ch_out;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0]     model_q [NCH][$];
  logic [CHW+DW-1:0] exp_q[$];
  logic              model_valid = 1'b0;
  int                model_last  = NCH - 1;
  logic [NCH-1:0]    model_ovf   = '0;
  logic [NCH-1:0]    model_full  = '0;
  bit                model_started = 1'b0;

  always #5 clk = ~clk;

  mux_rr_buffered #(
    .DATA_WIDTH(DW),
    .NUM_CH    (NCH),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .data_in  (data_in),
    .valid_in (valid_in),
    .out_ready(out_ready),
    .full     (full),
    .overflow (overflow),
    .valid_out(valid_out),
    .data_out (data_out),
    .ch_out   (ch_out)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic [NCH-1:0] vin,
                               input logic [NCH*DW-1:0] din, input logic rdy);
    @(posedge clk);
    #2;
    reset_L   = rst_n;
    valid_in  = vin;
    data_in   = din;
    out_ready = rdy;
  endtask

  // Behavioural model of one clock edge: arbitrate over pre-edge contents, then accept pushes.
  task automatic modelStep();
    logic [NCH-1:0] was_full;
    int g;
    int c;
    if (!reset_L) begin
      for (int i = 0; i < NCH; i++) model_q[i].delete();
      exp_q.delete();
      model_valid = 1'b0;
      model_last  = NCH - 1;
      model_ovf   = '0;
    end else begin
      for (int i = 0; i < NCH; i++) was_full[i] = (model_q[i].size() == DEPTH);
      if (!model_valid || out_ready) begin
        g = -1;
        for (int k = 1; k <= NCH; k++) begin
          c = (model_last + k) % NCH;
          if (g < 0 && model_q[c].size() > 0) g = c;
        end
        if (g >= 0) begin
          exp_q.push_back({CHW'(g), model_q[g].pop_front()});
          model_last  = g;
          model_valid = 1'b1;
        end else begin
          model_valid = 1'b0;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (valid_in[i]) begin
          if (was_full[i]) model_ovf[i] = 1'b1;
          else model_q[i].push_back(data_in[i*DW +: DW]);
        end
      end
    end
    for (int i = 0; i < NCH; i++) model_full[i] = (model_q[i].size() == DEPTH);
    model_started = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  initial begin : monitor
    logic [CHW+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (model_started) begin
        checkOutput("valid_out", 32'(valid_out), 32'(model_valid));
        checkOutput("full", 32'(full), 32'(model_full));
        checkOutput("overflow", 32'(overflow), 32'(model_ovf));
        if (!valid_out) begin
          checkOutput("idle data_out", 32'(data_out), 32'h0);
          checkOutput("idle ch_out", 32'(ch_out), 32'h0);
        end else if (exp_q.size() == 0) begin
          checkOutput("unexpected word", 32'(valid_out), 32'h0);
        end else begin
          e = exp_q[0];
          checkOutput("data_out", 32'(data_out), 32'(e[DW-1:0]));
          checkOutput("ch_out", 32'(ch_out), 32'(e[CHW+DW-1:DW]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n, input logic rdy);
    repeat (n) applyStimulus(1'b1, '0, '0, rdy);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || model_valid) && budget < 60) begin
      applyStimulus(1'b1, '0, '0, 1'b1);
      budget++;
    end
    checkOutput("drain timeout", 32'(budget >= 60), 32'h0);
  endtask

  initial begin
    reset_L   = 1'b0;
    valid_in  = '1;
    data_in   = '1;
    out_ready = 1'b0;

    // Reset held with all channels pushing
    applyStimulus(1'b0, '1, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b1);
    applyStimulus(1'b0, '1, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b1);
    @(negedge clk);
    checkOutput("reset valid_out", 32'(valid_out), 32'h0);
    checkOutput("reset overflow", 32'(overflow), 32'h0);

    // Single word latency
    applyStimulus(1'b1, 4'b0001, {24'h0, 8'hAA}, 1'b1);
    idle(4, 1'b1);

    // Round robin across all channels, then a sparse pair
    applyStimulus(1'b1, 4'b1111, {8'h40, 8'h30, 8'h20, 8'h10}, 1'b1);
    idle(5, 1'b1);
    applyStimulus(1'b1, 4'b1010, {8'h41, 8'h00, 8'h21, 8'h00}, 1'b1);
    idle(4, 1'b1);

    // Backpressure on channel 2 until it overflows
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 4'b0100, {8'h00, 8'hC0 + 8'(i), 16'h0}, 1'b0);
    idle(2, 1'b0);
    @(negedge clk);
    checkOutput("ovf2 sticky", 32'(overflow[2]), 32'h1);
    checkOutput("full2 held", 32'(full[2]), 32'h1);
    drain();

    // Full FIFO pushed in the same cycle it is popped
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 4'b0010, {16'h0, 8'hB0 + 8'(i), 8'h00}, 1'b0);
    applyStimulus(1'b1, 4'b0010, {16'h0, 8'hEE, 8'h00}, 1'b1);
    drain();

    // Reset while three FIFOs hold data
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 4'b0111, {8'h00, 8'h70 + 8'(i), 8'h60 + 8'(i), 8'h50 + 8'(i)}, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, 4'b1000, {8'h5A, 24'h0}, 1'b1);
    idle(4, 1'b1);

    // Randomised traffic with occasional reset
    for (int i = 0; i < 500; i++)
      applyStimulus(($urandom_range(0, 149) != 0), 4'($urandom),
                    32'($urandom), ($urandom_range(0, 3) != 0));
    drain();
    idle(2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
